// File: rtl/regfile_fifo_ctrl_if.sv
// Handshake and register-file control bundle between a FIFO user and the
// pointer controller of a 32x4 register-file FIFO.
interface regfile_fifo_ctrl_if;
    logic       push;
    logic       pop;
    logic [4:0] W_ADR;
    logic       W_en;
    logic [4:0] A_ADR;
    logic       out_valid;
    logic       full;
    logic       empty;
    logic [5:0] count;
    logic       ovf;
    logic       udf;

    modport master (
        output push, pop,
        input  W_ADR, W_en, A_ADR, out_valid, full, empty, count, ovf, udf
    );

    modport slave (
        input  push, pop,
        output W_ADR, W_en, A_ADR, out_valid, full, empty, count, ovf, udf
    );
endinterface

// File: rtl/regfile_fifo_ctrl.sv
// Pointer/occupancy controller for a 32-entry FIFO whose data lives in an
// external 32x4 register file; this block holds no data itself.
module regfile_fifo_ctrl #(
    parameter int NoConfigBits = 1
) (
    input  logic                    UserCLK,
    input  logic                    RESETn,
    input  logic [NoConfigBits-1:0] ConfigBits,
    regfile_fifo_ctrl_if.slave      bus
);

    logic [4:0] wr_ptr_reg;
    logic [4:0] rd_ptr_reg;
    logic [5:0] count_reg;
    logic       out_valid_reg;
    logic       ovf_reg;
    logic       udf_reg;

    logic       reg_mode;
    logic       full;
    logic       empty;
    logic       out_valid;
    logic       push_acc;
    logic       pop_acc;

    assign reg_mode  = ConfigBits[0];
    assign full      = (count_reg == 6'd32);
    assign empty     = (count_reg == 6'd0);
    // Registered port A needs a bubble after each pop for the new head to settle.
    assign out_valid = reg_mode ? out_valid_reg : ~empty;

    // RESETn gating keeps W_en quiet while reset is held, even with push high.
    assign push_acc = bus.push & ~full & RESETn;
    assign pop_acc  = bus.pop & out_valid;

    assign bus.W_ADR     = wr_ptr_reg;
    assign bus.A_ADR     = rd_ptr_reg;
    assign bus.W_en      = push_acc;
    assign bus.out_valid = out_valid;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.udf       = udf_reg;

    always_ff @(posedge UserCLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr_reg    <= 5'd0;
            rd_ptr_reg    <= 5'd0;
            count_reg     <= 6'd0;
            out_valid_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            udf_reg       <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_reg <= wr_ptr_reg + 5'd1;
            end
            if (pop_acc) begin
                rd_ptr_reg <= rd_ptr_reg + 5'd1;
            end
            count_reg     <= count_reg + {5'd0, push_acc} - {5'd0, pop_acc};
            out_valid_reg <= ~empty & ~pop_acc;
            if (bus.push && full) begin
                ovf_reg <= 1'b1;
            end
            if (bus.pop && !out_valid) begin
                udf_reg <= 1'b1;
            end
        end
    end

endmodule
